regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with write-to-read bypass and a per-register busy scoreboard. Sits in the decode/writeback stage of the pipelined core. It serves `NRD` combinational read ports and accepts `NWR` writeback ports per cycle. Issue logic uses the scoreboard to detect RAW hazards against in-flight producers without a separate hazard table.

## Interface
Parameters:
- `XLEN`, 32, data width in bits.
- `NREG`, 32, number of architectural registers. Must be a power of 2 and ≥ 4. `AW = $clog2(NREG)`.
- `NRD`, 2, number of read ports. Range 1..4.
- `NWR`, 1, number of write ports. Range 1..2.
- `SP_IDX`, 2, index of the stack-pointer register.
- `SP_INIT`, 508, reset value of register `SP_IDX`, i.e. (1<<9)-4.

Ports:
- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `we`  in  NWR  write enable per write port.
- `waddr`  in  NWR×AW  write address per port.
- `wdata`  in  NWR×XLEN  write data per port.
- `raddr`  in  NRD×AW  read address per port.
- `rdata`  out  NRD×XLEN  read data per port (combinational).
- `rbusy`  out  NRD  asserted when the register on the port has an outstanding producer.
- `alloc_en`  in  1  mark `alloc_addr` busy (instruction issued with a destination).
- `alloc_addr`  in  AW  destination being allocated.
- `flush`  in  1  synchronous clear of all busy bits (pipeline flush).

## Operation
- State:
  - `regs[1..NREG-1]`, XLEN bits each.
  - `busy[1..NREG-1]`, 1 bit each.
  - Register 0 has no storage. It reads 0 and is never busy.
- Reset (async, while `rst`=1):
  - `regs[SP_IDX]` = `SP_INIT`; all other regs = 0.
  - All busy bits = 0.
  - Outputs during reset follow the combinational rules below applied to reset state. `rdata` = 0, except port reading `SP_IDX` returns `SP_INIT`. `rbusy` = 0.
- Write:
  - At a rising edge, for each port p with `we[p]`=1 and `waddr[p]`≠0, `regs[waddr[p]]` ← `wdata[p]`.
  - Two ports writing the same address in the same cycle: the higher-index port wins.
  - Writes to address 0 are discarded.
- Read (combinational, per read port r):
  - `raddr[r]`=0 → `rdata`=0.
  - Otherwise, if any write port has `we`=1 and matching nonzero `waddr`, return the `wdata` of the highest-index matching port (bypass).
  - Otherwise, return `regs[raddr[r]]`.
- Scoreboard (next-state per register i≠0, priority high to low):
  1. `flush`=1 → busy[i] ← 0, for all i. Any same-cycle alloc is also dropped.
  2. `alloc_en`=1 and `alloc_addr`=i → busy[i] ← 1. This overrides a same-cycle writeback to i, because the new producer supersedes the old.
  3. Any `we[p]`=1 with `waddr[p]`=i → busy[i] ← 0.
  4. Otherwise hold.
  - `alloc_addr`=0 is ignored.
- `rbusy[r]` = busy[raddr[r]] AND NOT (a same-cycle write matches `raddr[r]`).
  - A value being written this cycle is available through the bypass, so it is not reported busy.
  - Alloc does not affect `rbusy` until the following cycle.

## Timing
- Read latency: 0 cycles (combinational from `raddr`, `we`, `waddr`, `wdata`).
- Write latency: written value is visible via bypass in the same cycle. It is visible from storage from the next cycle.
- Busy set: `alloc_en` at edge N → `rbusy` high from cycle N+1.
- Busy clear: writeback in cycle M → `rbusy` low in cycle M (bypass) and thereafter.
- `rst` asserted mid-operation: state clears immediately, with no clock needed.
- `rst` deassertion is synchronised externally. The block assumes it is released away from the rising edge.
- No stall or handshake outputs. The register file always accepts writes and allocs.

## Test plan
- Reset: assert `rst` with no clock → read x2 = 508, x5 = 0, x0 = 0, all `rbusy` = 0.
- Write/read and bypass:
  - `we`=1, `waddr`=5, `wdata`=0xDEADBEEF, `raddr[0]`=5 in the same cycle → `rdata[0]`=0xDEADBEEF before the edge.
  - After the edge, with `we`=0 → still 0xDEADBEEF.
  - Write x0=0x1234 → read x0 = 0.
- Dual write conflict (NWR=2): both ports write x7, port0=0x11 and port1=0x22 → bypass and stored value are both 0x22.
- Scoreboard:
  - `alloc_en` x9 at edge N → `rbusy` for x9 = 1 at cycles N+1…M-1.
  - Writeback x9 in cycle M → `rbusy`=0 in cycle M, `rdata`=`wdata`.
  - Alloc x9 and write x9 in the same cycle → busy stays 1 next cycle.
- Flush: allocate x3, x4, x10; pulse `flush` together with `alloc_en` x11 → next cycle all four report `rbusy`=0.
- Async reset mid-run: write x2=0x100, then assert `rst` between edges → x2 reads 508 immediately and busy bits clear.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass and a per-register busy scoreboard.
// Reads and rbusy are combinational (0 cycles); writes and allocs land on the next edge; never stalls.
module regfile_mp #(
    parameter  int XLEN    = 32,
    parameter  int NREG    = 32,
    parameter  int NRD     = 2,
    parameter  int NWR     = 1,
    parameter  int SP_IDX  = 2,
    parameter  int SP_INIT = 508,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*AW-1:0]     waddr,
    input  logic [NWR*XLEN-1:0]   wdata,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*XLEN-1:0]   rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  alloc_en,
    input  logic [AW-1:0]         alloc_addr,
    input  logic                  flush
);

    localparam logic [XLEN-1:0] SP_VAL = XLEN'(SP_INIT);

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];
    logic [NREG-1:1] busy_q;
    logic [NREG-1:1] busy_d;

    // Per-register write decode shared by storage update, bypass and busy clear.
    // Ports are scanned in ascending order so the highest-index match wins.
    logic [NREG-1:1] wr_hit;
    logic [XLEN-1:0] wr_val [1:NREG-1];

    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            wr_hit[i] = 1'b0;
            wr_val[i] = '0;
            for (int p = 0; p < NWR; p++) begin
                if (we[p] && (waddr[p*AW +: AW] == AW'(i))) begin
                    wr_hit[i] = 1'b1;
                    wr_val[i] = wdata[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Alloc outranks writeback: the newly issued producer supersedes the one retiring.
    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            regs_d[i] = wr_hit[i] ? wr_val[i] : regs_q[i];
            if (flush) begin
                busy_d[i] = 1'b0;
            end else if (alloc_en && (alloc_addr == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wr_hit[i]) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_VAL : '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Address 0 matches no entry, so it reads zero and is never busy.
    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rdata[r*XLEN +: XLEN] = '0;
            rbusy[r]              = 1'b0;
            for (int i = 1; i < NREG; i++) begin
                if (raddr[r*AW +: AW] == AW'(i)) begin
                    rdata[r*XLEN +: XLEN] = wr_hit[i] ? wr_val[i] : regs_q[i];
                    rbusy[r]              = busy_q[i] & ~wr_hit[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed-vector bench for regfile_mp with two read and two write ports.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        we;
    logic [2*AW-1:0]   waddr;
    logic [2*XLEN-1:0] wdata;
    logic [2*AW-1:0]   raddr;
    logic [2*XLEN-1:0] rdata;
    logic [1:0]        rbusy;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic              flush;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .SP_IDX(2), .SP_INIT(508)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      we;
        logic [AW-1:0]   wa0;
        logic [XLEN-1:0] wd0;
        logic [AW-1:0]   wa1;
        logic [XLEN-1:0] wd1;
        logic [AW-1:0]   ra0;
        logic [AW-1:0]   ra1;
        logic            al;
        logic [AW-1:0]   aa;
        logic            fl;
        logic [XLEN-1:0] e0;
        logic [XLEN-1:0] e1;
        logic [1:0]      eb;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        we         = v.we;
        waddr      = {v.wa1, v.wa0};
        wdata      = {v.wd1, v.wd0};
        raddr      = {v.ra1, v.ra0};
        alloc_en   = v.al;
        alloc_addr = v.aa;
        flush      = v.fl;
    endtask

    task automatic idle_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        we = 2'b00; waddr = '0; wdata = '0; alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
        raddr = {a1, a0};
    endtask

    initial begin
        rst = 1'b1;
        idle_read(5'd2, 5'd5);

        // Reset is asynchronous: check before the first clock edge.
        #2;
        check("rst_x2", rdata[31:0], 32'd508);
        check("rst_x5", rdata[63:32], 32'd0);
        check("rst_rbusy", {30'd0, rbusy}, 32'd0);
        raddr = {5'd0, 5'd0};
        #1;
        check("rst_x0", rdata[31:0], 32'd0);

        // we, wa0, wd0, wa1, wd1, ra0, ra1, al, aa, fl, e0, e1, eb
        vq.push_back('{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        5'd5,  5'd2,  1'b0, 5'd0,  1'b0, 32'hDEADBEEF, 32'd508,      2'b00});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd5,  5'd0,  1'b0, 5'd0,  1'b0, 32'hDEADBEEF, 32'd0,        2'b00});
        vq.push_back('{2'b01, 5'd0,  32'h1234,     5'd0,  32'h0,        5'd0,  5'd5,  1'b0, 5'd0,  1'b0, 32'd0,        32'hDEADBEEF, 2'b00});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd0,  5'd5,  1'b0, 5'd0,  1'b0, 32'd0,        32'hDEADBEEF, 2'b00});
        vq.push_back('{2'b11, 5'd7,  32'h11,       5'd7,  32'h22,       5'd7,  5'd7,  1'b0, 5'd0,  1'b0, 32'h22,       32'h22,       2'b00});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd7,  5'd2,  1'b0, 5'd0,  1'b0, 32'h22,       32'd508,      2'b00});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd7,  1'b1, 5'd9,  1'b0, 32'd0,        32'h22,       2'b00});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd7,  1'b0, 5'd0,  1'b0, 32'd0,        32'h22,       2'b01});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd9,  1'b0, 5'd0,  1'b0, 32'd0,        32'd0,        2'b11});
        vq.push_back('{2'b10, 5'd0,  32'h0,        5'd9,  32'hCAFE0009, 5'd9,  5'd9,  1'b0, 5'd0,  1'b0, 32'hCAFE0009, 32'hCAFE0009, 2'b00});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd0,  1'b0, 5'd0,  1'b0, 32'hCAFE0009, 32'd0,        2'b00});
        vq.push_back('{2'b01, 5'd9,  32'h99,       5'd0,  32'h0,        5'd9,  5'd7,  1'b1, 5'd9,  1'b0, 32'h99,       32'h22,       2'b00});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd7,  1'b0, 5'd0,  1'b0, 32'h99,       32'h22,       2'b01});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd3,  1'b1, 5'd3,  1'b0, 32'h99,       32'd0,        2'b01});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd3,  5'd9,  1'b1, 5'd4,  1'b0, 32'd0,        32'h99,       2'b11});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd4,  5'd3,  1'b1, 5'd10, 1'b0, 32'd0,        32'd0,        2'b11});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd10, 5'd4,  1'b1, 5'd11, 1'b1, 32'd0,        32'd0,        2'b11});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd10, 5'd11, 1'b0, 5'd0,  1'b0, 32'd0,        32'd0,        2'b00});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd3,  5'd4,  1'b0, 5'd0,  1'b0, 32'd0,        32'd0,        2'b00});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd2,  1'b0, 5'd0,  1'b0, 32'h99,       32'd508,      2'b00});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd0,  5'd2,  1'b1, 5'd0,  1'b0, 32'd0,        32'd508,      2'b00});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd0,  5'd9,  1'b0, 5'd0,  1'b0, 32'd0,        32'h99,       2'b00});
        vq.push_back('{2'b11, 5'd12, 32'hAAAA,     5'd13, 32'hBBBB,     5'd12, 5'd13, 1'b0, 5'd0,  1'b0, 32'hAAAA,     32'hBBBB,     2'b00});
        vq.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd12, 5'd13, 1'b0, 5'd0,  1'b0, 32'hAAAA,     32'hBBBB,     2'b00});

        @(negedge clk);
        rst = 1'b0;

        // Inputs change on the falling edge, outputs are sampled 1ns later.
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            #1;
            check($sformatf("v%0d_rd0", i), rdata[31:0],  vq[i].e0);
            check($sformatf("v%0d_rd1", i), rdata[63:32], vq[i].e1);
            check($sformatf("v%0d_rb0", i), {31'd0, rbusy[0]}, {31'd0, vq[i].eb[0]});
            check($sformatf("v%0d_rb1", i), {31'd0, rbusy[1]}, {31'd0, vq[i].eb[1]});
            @(negedge clk);
        end

        // Mid-run asynchronous reset between clock edges.
        idle_read(5'd2, 5'd5);
        we = 2'b01; waddr = {5'd0, 5'd2}; wdata = {32'h0, 32'h100};
        alloc_en = 1'b1; alloc_addr = 5'd5;
        @(negedge clk);
        idle_read(5'd2, 5'd5);
        #1;
        check("pre_rst_x2", rdata[31:0], 32'h100);
        check("pre_rst_busy5", {31'd0, rbusy[1]}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_x2", rdata[31:0], 32'd508);
        check("async_rst_busy5", {31'd0, rbusy[1]}, 32'd0);
        raddr = {5'd12, 5'd7};
        #1;
        check("async_rst_x7", rdata[31:0], 32'd0);
        check("async_rst_x12", rdata[63:32], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_read(5'd2, 5'd5);
        @(negedge clk);
        #1;
        check("post_rst_x2", rdata[31:0], 32'd508);
        check("post_rst_busy", {30'd0, rbusy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
